cic_decim_ctrl: RTL
===================

// Module: cic_decim_ctrl
// PURPOSE
//  Run-time controller for the AM-demod CIC decimator.
//  Owns the decimation ratio, range-checks reconfiguration requests and pulses the CIC reset to apply a new ratio.
//  Discards the transient output samples after each (re)start, then re-times CIC output samples into the clk domain as a valid strobe.
//  A watchdog restarts the CIC if its decimated clock stalls.
//  Sits between the control/register interface and the CIC instance.
// PARAMETERS
//  DW             8      CIC output sample width (signed)
//  RW             16     decimation ratio width
//  DEFAULT_RATIO  12500  ratio loaded at reset
//  MIN_RATIO      8      smallest accepted ratio (>= sync+edge latency + margin)
//  RST_CYCLES     4      clk cycles cic_rst is held high per restart
//  SETTLE_SAMPLES 4      d_clk edges discarded after restart (= CIC order)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-low reset
//  cfg_ratio      in   RW  requested decimation ratio
//  cfg_wr         in   1   1-cycle write strobe for cfg_ratio
//  cfg_ack        out  1   1-cycle pulse: request accepted
//  cfg_err        out  1   1-cycle pulse: request rejected (out of range)
//  cic_rst        out  1   active-high reset to CIC
//  cic_ratio      out  RW  ratio driven to CIC decimation_ratio
//  cic_dclk       in   1   CIC decimated clock (d_clk)
//  cic_dout       in   DW  CIC output sample
//  out_data       out  DW  registered captured sample
//  out_valid      out  1   1-cycle strobe, out_data valid
//  running        out  1   high in RUN state
//  stall          out  1   1-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset (rst=0): cic_ratio=DEFAULT_RATIO, state=FLUSH, cic_rst=1, all pulses/out_data/out_valid/running=0.
//  cic_dclk path: 2-FF synchronizer + edge register.
//    Rising edge is detected 3 clk after the raw edge.
//    On a detected edge, cic_dout is sampled directly (stable for >= MIN_RATIO cycles).
//  FSM:
//    FLUSH : cic_rst=1 for RST_CYCLES clk; clear edge/settle/watchdog counters -> SETTLE.
//    SETTLE: count detected edges, drop samples; at SETTLE_SAMPLES-th edge -> RUN (that sample also dropped).
//    RUN   : running=1; each detected edge -> out_data<=cic_dout, out_valid=1 next cycle.
//  cfg_wr (any state): accept if MIN_RATIO <= cfg_ratio.
//    On accept: cic_ratio<=cfg_ratio, cfg_ack=1 next cycle, ->FLUSH.
//    On reject: cfg_err=1, state and ratio unchanged.
//    cfg_wr during FLUSH restarts the RST_CYCLES count.
//  cfg_wr on same cycle as detected edge in RUN: config wins, sample dropped, no out_valid.
//  Watchdog (SETTLE/RUN): counter RW+2 bits, cleared on each detected edge.
//    Reaching 2*cic_ratio+16 -> stall=1, ->FLUSH, ratio kept.
//    Counter saturates, never wraps.
//  No outputs change combinationally from inputs; all outputs registered.
// TESTING
//  1 Reset, model CIC d_clk period 2*ratio -> cic_rst high 4 clk; first 4 edges give no out_valid; 5th gives out_valid with matching cic_dout.
//  2 In RUN, cfg_wr cfg_ratio=100 -> cfg_ack next clk, cic_ratio=100, cic_rst 4 clk, running=0 until 4 more edges.
//  3 cfg_wr cfg_ratio=3 -> cfg_err pulse, cic_ratio unchanged, out_valid stream uninterrupted.
//  4 Stop d_clk in RUN at ratio=100 -> stall after 216 clk without edge, FLUSH, then recovery once d_clk resumes.
//  5 cfg_wr coincident with detected edge -> ack, no out_valid that cycle; rst asserted mid-SETTLE -> immediate reset values.
//  6 Back-to-back cfg_wr (ratio 50 then 60) in FLUSH -> cic_ratio=60, cic_rst held 4 clk after the second write.

Source files
------------

// File: rtl/cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// cic_decim_ctrl
//   Run-time controller for the AM-demodulator CIC decimator.
//   - Holds the decimation ratio and range-checks reconfiguration writes.
//   - Pulses the CIC reset for RST_CYCLES clocks to apply a new ratio.
//   - Drops the first SETTLE_SAMPLES decimated samples after each restart
//     while the integrator/comb chain fills.
//   - Re-times CIC output samples into the clk domain as a valid strobe.
//   - Restarts the CIC when its decimated clock stalls (watchdog).
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   cfg_ratio  in   requested decimation ratio (RW bits)
//   cfg_wr     in   one-cycle write strobe for cfg_ratio
//   cfg_ack    out  one-cycle pulse, request accepted
//   cfg_err    out  one-cycle pulse, request rejected (below MIN_RATIO)
//   cic_rst    out  active-high reset to the CIC
//   cic_ratio  out  ratio driven to the CIC
//   cic_dclk   in   CIC decimated clock (asynchronous to clk)
//   cic_dout   in   CIC output sample (DW bits, signed)
//   out_data   out  captured sample
//   out_valid  out  one-cycle strobe, out_data valid
//   running    out  high while samples are being forwarded
//   stall      out  one-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module cic_decim_ctrl #(
  parameter int unsigned DW             = 8,
  parameter int unsigned RW             = 16,
  parameter int unsigned DEFAULT_RATIO  = 12500,
  parameter int unsigned MIN_RATIO      = 8,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned SETTLE_SAMPLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] cfg_ratio,
  input  logic          cfg_wr,
  output logic          cfg_ack,
  output logic          cfg_err,
  output logic          cic_rst,
  output logic [RW-1:0] cic_ratio,
  input  logic          cic_dclk,
  input  logic [DW-1:0] cic_dout,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          running,
  output logic          stall
);

  localparam int unsigned WDW = RW + 2;
  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned SCW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [RCW-1:0] RST_LAST    = RCW'(RST_CYCLES - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_SETTLE,
    ST_RUN
  } state_e;

  state_e         state_q;
  logic [RW-1:0]  ratio_q;
  logic [RCW-1:0] rst_cnt_q;
  logic [SCW-1:0] settle_cnt_q;
  logic [WDW-1:0] wd_cnt_q;
  logic           cic_rst_q;
  logic           ack_q;
  logic           err_q;
  logic           stall_q;
  logic           valid_q;
  logic           running_q;
  logic [DW-1:0]  out_data_q;

  // Two synchronizer stages followed by the edge register.
  logic [2:0]     dclk_sync_q;
  logic           dclk_rise;
  logic           cfg_accept;
  logic [WDW-1:0] wd_trip;

  // NOTE: every clocked register uses non-blocking assignments so all of them
  // update together from the values that existed before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dclk_sync_q <= '0;
    end else begin
      dclk_sync_q <= {dclk_sync_q[1:0], cic_dclk};
    end
  end

  assign dclk_rise  = dclk_sync_q[1] & ~dclk_sync_q[2];
  assign cfg_accept = cfg_wr & (cfg_ratio >= RW'(MIN_RATIO));

  // The watchdog trips when the counter would reach 2*ratio+16, i.e. when it
  // already holds 2*ratio+15 and another edge-free cycle passes.
  assign wd_trip = ({2'b00, ratio_q} << 1) + WDW'(15);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_FLUSH;
      ratio_q      <= RW'(DEFAULT_RATIO);
      rst_cnt_q    <= '0;
      settle_cnt_q <= '0;
      wd_cnt_q     <= '0;
      cic_rst_q    <= 1'b1;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
      valid_q      <= 1'b0;
      running_q    <= 1'b0;
      out_data_q   <= '0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      valid_q <= 1'b0;

      if (cfg_accept) begin
        // A new ratio always restarts the CIC; an edge arriving in the same
        // cycle is dropped because the CIC is about to be reset anyway.
        ratio_q   <= cfg_ratio;
        ack_q     <= 1'b1;
        state_q   <= ST_FLUSH;
        rst_cnt_q <= '0;
        cic_rst_q <= 1'b1;
        running_q <= 1'b0;
      end else begin
        err_q <= cfg_wr;
        unique case (state_q)
          ST_FLUSH: begin
            settle_cnt_q <= '0;
            wd_cnt_q     <= '0;
            if (rst_cnt_q == RST_LAST) begin
              state_q   <= ST_SETTLE;
              cic_rst_q <= 1'b0;
            end else begin
              rst_cnt_q <= rst_cnt_q + RCW'(1);
            end
          end

          ST_SETTLE, ST_RUN: begin
            if (dclk_rise) begin
              wd_cnt_q <= '0;
              if (state_q == ST_SETTLE) begin
                // Transient samples are discarded, including the last one.
                if (settle_cnt_q == SETTLE_LAST) begin
                  state_q   <= ST_RUN;
                  running_q <= 1'b1;
                end else begin
                  settle_cnt_q <= settle_cnt_q + SCW'(1);
                end
              end else begin
                // cic_dout has been stable for many cycles by the time the
                // synchronized edge arrives, so it is sampled directly.
                out_data_q <= cic_dout;
                valid_q    <= 1'b1;
              end
            end else if (wd_cnt_q >= wd_trip) begin
              stall_q   <= 1'b1;
              state_q   <= ST_FLUSH;
              rst_cnt_q <= '0;
              cic_rst_q <= 1'b1;
              running_q <= 1'b0;
            end else if (wd_cnt_q != '1) begin
              wd_cnt_q <= wd_cnt_q + WDW'(1);
            end
          end

          default: begin
            state_q   <= ST_FLUSH;
            rst_cnt_q <= '0;
            cic_rst_q <= 1'b1;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;
  assign cic_rst   = cic_rst_q;
  assign cic_ratio = ratio_q;
  assign out_data  = out_data_q;
  assign out_valid = valid_q;
  assign running   = running_q;
  assign stall     = stall_q;

endmodule
